// File: rtl/fifo_rd_serializer.sv
// Drains a fall-through FIFO read port and sends each popped word as a framed
// LSB-first serial stream: start, data, optional even parity, stop.
module fifo_rd_serializer #(
  parameter int unsigned DWID    = 16,
  parameter int unsigned BIT_CYC = 4,
  parameter int unsigned PAR_EN  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            empty_i,
  input  logic [DWID-1:0] rdata_i,
  output logic            rd_o,
  output logic            ser_o,
  output logic            busy_o,
  output logic            frm_done_o
);

  localparam int unsigned CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int unsigned BW = $clog2(DWID);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYC - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DWID - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DWID-1:0] shreg_q, shreg_d;
  logic            par_q, par_d;
  logic            last_cyc;
  logic            pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
    end
  end

  // Next-state decode; a pop overrides everything and starts a fresh frame.
  always_comb begin
    state_d    = state_q;
    cyc_d      = '0;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    last_cyc   = (cyc_q == CYC_LAST);
    pop        = !rst && en_i && !empty_i &&
                 ((state_q == IDLE) || ((state_q == STOP) && last_cyc));
    rd_o       = pop;
    busy_o     = (state_q != IDLE);
    frm_done_o = (state_q == STOP) && last_cyc;
    ser_o      = 1'b1;

    if (state_q != IDLE && !last_cyc) begin
      cyc_d = cyc_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        ser_o = 1'b1;
      end
      START: begin
        ser_o = 1'b0;
        if (last_cyc) state_d = DATA;
      end
      DATA: begin
        ser_o = shreg_q[0];
        if (last_cyc) begin
          shreg_d = {1'b0, shreg_q[DWID-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PAR_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        ser_o = par_q;
        if (last_cyc) state_d = STOP;
      end
      STOP: begin
        ser_o = 1'b1;
        if (last_cyc) state_d = IDLE;
      end
      default: begin
        ser_o   = 1'b1;
        state_d = IDLE;
      end
    endcase

    if (pop) begin
      shreg_d = rdata_i;
      par_d   = ^rdata_i;
      cyc_d   = '0;
      bit_d   = '0;
      state_d = START;
    end
  end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Directed bench for fifo_rd_serializer: default instance plus a DWID=8,
// BIT_CYC=1, PAR_EN=0 instance, each fed by a small FIFO model.
module tb_fifo_rd_serializer;

  logic        clk;
  logic        rst;
  logic        en_i;
  logic        empty_i;
  logic [15:0] rdata_i;
  logic        rd_o, ser_o, busy_o, frm_done_o;

  logic        s_en;
  logic        s_empty;
  logic [7:0]  s_rdata;
  logic        s_rd, s_ser, s_busy, s_done;

  logic [15:0] mem [0:15];
  int          wr_ptr;
  int          rd_ptr;
  int          s_wr;
  int          s_rdc;

  int checks;
  int failures;

  fifo_rd_serializer #(.DWID(16), .BIT_CYC(4), .PAR_EN(1)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .empty_i(empty_i), .rdata_i(rdata_i),
    .rd_o(rd_o), .ser_o(ser_o), .busy_o(busy_o), .frm_done_o(frm_done_o)
  );

  fifo_rd_serializer #(.DWID(8), .BIT_CYC(1), .PAR_EN(0)) dut_s (
    .clk(clk), .rst(rst), .en_i(s_en), .empty_i(s_empty), .rdata_i(s_rdata),
    .rd_o(s_rd), .ser_o(s_ser), .busy_o(s_busy), .frm_done_o(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO models: head pointers advance on each pop strobe.
  assign empty_i = (wr_ptr == rd_ptr);
  assign rdata_i = mem[rd_ptr[3:0]];
  assign s_empty = (s_wr == s_rdc);

  always @(posedge clk) begin
    if (rd_o) rd_ptr <= rd_ptr + 1;
    if (s_rd) s_rdc  <= s_rdc + 1;
  end

  // Expected serial bit k cycles after a pop, default instance.
  function automatic logic exp_ser(input logic [15:0] w, input int k);
    int idx;
    idx = (k - 1) / 4;
    if (idx == 0)       return 1'b0;
    else if (idx <= 16) return w[idx-1];
    else if (idx == 17) return ^w;
    else                return 1'b1;
  endfunction

  task automatic push(input logic [15:0] w);
    mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset;
    logic [3:0] obs, obs_s;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    obs   = {rd_o, ser_o, busy_o, frm_done_o};
    obs_s = {s_rd, s_ser, s_busy, s_done};
    checks++;
    if (obs !== 4'b0100) begin
      failures++;
      $display("FAIL reset_main rd/ser/busy/done got %b want 0100", obs);
    end
    checks++;
    if (obs_s !== 4'b0100) begin
      failures++;
      $display("FAIL reset_small rd/ser/busy/done got %b want 0100", obs_s);
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [3:0] obs, exp;
    logic [15:0] w;
    w = 16'hA5C3;
    en_i = 1'b1;
    push(w);
    #1;
    checks++;
    if (rd_o !== 1'b1) begin
      failures++;
      $display("FAIL single_pop rd_o got %b want 1", rd_o);
    end
    for (int k = 1; k <= 77; k++) begin
      @(negedge clk);
      obs = {rd_o, ser_o, busy_o, frm_done_o};
      exp = (k == 77) ? 4'b0100 : {1'b0, exp_ser(w, k), 1'b1, (k == 76)};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL single_frame cyc=%0d got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] obs, exp;
    logic [15:0] w0, w1;
    w0 = 16'h0001;
    w1 = 16'h8000;
    push(w0);
    push(w1);
    #1;
    checks++;
    if (rd_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b_pop0 rd_o got %b want 1", rd_o);
    end
    for (int k = 1; k <= 153; k++) begin
      @(negedge clk);
      obs = {rd_o, ser_o, busy_o, frm_done_o};
      if (k == 153)     exp = 4'b0100;
      else if (k <= 76) exp = {(k == 76), exp_ser(w0, k), 1'b1, (k == 76)};
      else              exp = {1'b0, exp_ser(w1, k - 76), 1'b1, (k == 152)};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL b2b_frame cyc=%0d got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_empty;
    logic [3:0] obs;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      obs = {rd_o, ser_o, busy_o, frm_done_o};
      checks++;
      if (obs !== 4'b0100) begin
        failures++;
        $display("FAIL empty_idle cyc=%0d got %b want 0100", k, obs);
      end
    end
  endtask

  task automatic test_disabled;
    logic [3:0] obs;
    en_i = 1'b0;
    push(16'h1234);
    #1;
    for (int k = 0; k < 50; k++) begin
      obs = {rd_o, ser_o, busy_o, frm_done_o};
      checks++;
      if (obs !== 4'b0100) begin
        failures++;
        $display("FAIL disabled_idle cyc=%0d got %b want 0100", k, obs);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_en_drop;
    logic [3:0] obs, exp;
    logic [15:0] w;
    w = 16'h1234;
    push(16'h5678);
    en_i = 1'b1;
    #1;
    checks++;
    if (rd_o !== 1'b1) begin
      failures++;
      $display("FAIL endrop_pop rd_o got %b want 1", rd_o);
    end
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      obs = {rd_o, ser_o, busy_o, frm_done_o};
      exp = (k > 76) ? 4'b0100 : {1'b0, exp_ser(w, k), 1'b1, (k == 76)};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL endrop_frame cyc=%0d got %b want %b", k, obs, exp);
      end
      if (k == 26) en_i = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] obs, exp;
    logic [15:0] w;
    w = 16'h5678;
    en_i = 1'b1;
    #1;
    checks++;
    if (rd_o !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pop rd_o got %b want 1", rd_o);
    end
    for (int k = 1; k <= 38; k++) begin
      @(negedge clk);
      obs = {rd_o, ser_o, busy_o, frm_done_o};
      exp = {1'b0, exp_ser(w, k), 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL rstmid_frame cyc=%0d got %b want %b", k, obs, exp);
      end
    end
    rst = 1'b1;
    push(16'h9ABC);
    #1;
    checks++;
    if (rd_o !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_rd_in_rst rd_o got %b want 0", rd_o);
    end
    @(negedge clk);
    obs = {rd_o, ser_o, busy_o, frm_done_o};
    checks++;
    if (obs !== 4'b0100) begin
      failures++;
      $display("FAIL rstmid_after_rst got %b want 0100", obs);
    end
    rst = 1'b0;
    w = 16'h9ABC;
    #1;
    checks++;
    if (rd_o !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_repop rd_o got %b want 1", rd_o);
    end
    for (int k = 1; k <= 77; k++) begin
      @(negedge clk);
      obs = {rd_o, ser_o, busy_o, frm_done_o};
      exp = (k == 77) ? 4'b0100 : {1'b0, exp_ser(w, k), 1'b1, (k == 76)};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL rstmid_newframe cyc=%0d got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_small_nopar;
    logic [3:0] obs, exp;
    logic [9:0] bits;
    bits = 10'b11_0000_0010;
    s_rdata = 8'h81;
    s_wr = s_wr + 1;
    #1;
    checks++;
    if (s_rd !== 1'b1) begin
      failures++;
      $display("FAIL small_pop rd_o got %b want 1", s_rd);
    end
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      obs = {s_rd, s_ser, s_busy, s_done};
      exp = (k == 11) ? 4'b0100 : {1'b0, bits[k-1], 1'b1, (k == 10)};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL small_frame cyc=%0d got %b want %b", k, obs, exp);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    wr_ptr   = 0;
    rd_ptr   = 0;
    s_wr     = 0;
    s_rdc    = 0;
    rst      = 1'b1;
    en_i     = 1'b0;
    s_en     = 1'b1;
    s_rdata  = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;

    test_reset;
    test_single;
    test_back_to_back;
    test_empty;
    test_disabled;
    test_en_drop;
    test_reset_mid;
    test_small_nopar;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_serializer.md
# fifo_rd_serializer

Read-side drain engine for the synchronous FIFO. It pops words from the FIFO's fall-through read port and sends each one LSB-first as a framed serial bit stream. Frame format: start bit, data bits, optional even parity, stop bit. It sits between the FIFO read port and an off-block serial line. Frames are sent back-to-back whenever the FIFO holds data.

## Interface
- DWID, 16: data word width; must match FIFO DWID; ≥2
- BIT_CYC, 4: clock cycles per serial bit; ≥1
- PAR_EN, 1: 1 = even-parity bit inserted after data; 0 = no parity bit
- clk  input  1  sole clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- en_i  input  1  permit new pops; a frame in progress always completes
- empty_i  input  1  FIFO empty flag
- rdata_i  input  DWID  FIFO read data; fall-through, valid whenever empty_i=0
- rd_o  output  1  FIFO pop strobe; single cycle per word
- ser_o  output  1  serial line; idle high
- busy_o  output  1  high while a frame is in progress
- frm_done_o  output  1  one-cycle pulse in the final cycle of each stop bit

## Operation
- States: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PAR_EN=0.
- Pop condition: `pop = en_i && !empty_i && (state==IDLE || last cycle of STOP)`.
  - rd_o = pop, decoded combinationally from current state, counters, en_i and empty_i.
  - On the edge where pop=1: load the shift register with rdata_i, load the parity register with ^rdata_i, clear the counters, go to START.
- IDLE: ser_o=1, busy_o=0. Stay in IDLE until pop.
- START: ser_o=0 for BIT_CYC cycles, then DATA.
- DATA: ser_o=shreg[0].
  - At the end of each bit period, shift right and increment the bit counter.
  - After bit DWID-1 go to PARITY, or to STOP if PAR_EN=0.
- PARITY: ser_o = XOR of the loaded word, so the data bits plus the parity bit contain an even number of ones. Lasts BIT_CYC cycles.
- STOP: ser_o=1 for BIT_CYC cycles.
  - frm_done_o=1 in the last of those cycles.
  - From that cycle: go to START if pop, else go to IDLE.
- Counters:
  - Cycle counter: width max(1,$clog2(BIT_CYC)), counts 0..BIT_CYC-1 and wraps to 0 on each bit boundary.
  - Bit counter: width $clog2(DWID), counts 0..DWID-1.
  - No other arithmetic.
- ser_o is taken directly from the state register and shift register (glitch-free). busy_o = (state != IDLE).
- en_i deasserted mid-frame: the current frame finishes unchanged; no pop in the last STOP cycle; return to IDLE.
- empty_i rising mid-frame has no effect on the current frame. rdata_i is sampled only on the pop edge.
- rd_o is never asserted while empty_i=1, so the FIFO sees no underflow.
- Reset:
  - Next cycle: state=IDLE, ser_o=1, busy_o=0, rd_o=0, frm_done_o=0, counters=0, shreg=0.
  - Reset mid-frame abandons the frame. The already-popped word is lost and is not re-read.
  - rd_o is forced 0 in any cycle where rst=1.

## Timing
- Frame length F = (2 + DWID + PAR_EN) × BIT_CYC cycles; default 76.
- Pop in cycle T:
  - start bit occupies T+1 .. T+BIT_CYC
  - data bit i occupies T+1+(1+i)·BIT_CYC .. T+(2+i)·BIT_CYC
  - frm_done_o is high in cycle T+F
- Back-to-back: the next pop occurs in cycle T+F, and its start bit begins at T+F+1. There is no idle gap between frames. rd_o pulses are spaced exactly F cycles apart.
- From IDLE, the latency from empty_i falling (with en_i=1) to rd_o is 0 cycles (combinational). ser_o falls 1 cycle later.
- BIT_CYC=1: each state lasts exactly one cycle, except DATA, which lasts DWID cycles.

## Test plan
- Single word, defaults: FIFO holds 16'hA5C3, en_i=1.
  - Required: rd_o high one cycle.
  - Required: ser_o reads 0, then 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (LSB-first), then parity 0, then stop 1; each bit lasts 4 cycles.
  - Required: frm_done_o at cycle 76 after the pop; busy_o then falls.
- Back-to-back: FIFO holds 16'h0001, then 16'h8000.
  - Required: exactly two rd_o pulses, 76 cycles apart; no ser_o idle-high gap beyond the stop bit.
  - Required: parity bits 1 and 1.
- Empty / disabled:
  - empty_i=1 for 200 cycles → rd_o=0, ser_o=1, busy_o=0.
  - en_i=0 with a non-empty FIFO → likewise, no pops.
- en_i dropped in data bit 5 of a frame, FIFO still non-empty → current frame completes, then IDLE; no second rd_o.
- rst=1 in data bit 8 → next cycle ser_o=1, busy_o=0, rd_o=0. After release, the next FIFO word is sent as a full frame.
- PAR_EN=0, BIT_CYC=1, DWID=8, word 8'h81 → ser_o = 0,1,0,0,0,0,0,0,1,1 over 10 cycles; frm_done_o on the 10th cycle.
